// File: rtl/ledcomm_txq_pkg.sv
// Shared types and constants for the Ledcomm transmit queue.
//   BYTE_W      : width of one queued byte
//   LC_WORD_W   : width of the word presented to the Ledcomm transmitter
//   LC_PAD      : upper byte padding of the Ledcomm word
//   ing_state_e : ingress (UART side) FSM states
//   egr_state_e : egress (Ledcomm side) FSM states
package ledcomm_txq_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned LC_WORD_W = 16;
  localparam logic [BYTE_W-1:0] LC_PAD = 8'h00;

  typedef enum logic [1:0] {
    ING_IDLE = 2'd0,
    ING_GAP  = 2'd1
  } ing_state_e;

  typedef enum logic [1:0] {
    EGR_IDLE   = 2'd0,
    EGR_LOAD   = 2'd1,
    EGR_STROBE = 2'd2,
    EGR_SETTLE = 2'd3
  } egr_state_e;

endpackage

// File: rtl/ledcomm_txq_fifo.sv
// Byte FIFO with synchronous-write RAM, registered read word and
// registered status flags.
//   clk, resetq   : clock, synchronous active-low reset
//   push_i        : single-cycle write strobe (ignored when full)
//   push_data_i   : byte to write
//   pop_i         : single-cycle read-advance strobe (ignored when empty)
//   rd_data_o     : byte at the read pointer, registered from the RAM
//   level_o       : fill count 0..2**DEPTH_LOG2
//   full_o        : level == 2**DEPTH_LOG2
//   empty_o       : level == 0
//   afull_o       : level >= AFULL_LEVEL
module ledcomm_txq_fifo
  import ledcomm_txq_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 4,
  parameter int unsigned AFULL_LEVEL = 12
) (
  input  logic                  clk,
  input  logic                  resetq,
  input  logic                  push_i,
  input  logic [BYTE_W-1:0]     push_data_i,
  input  logic                  pop_i,
  output logic [BYTE_W-1:0]     rd_data_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  afull_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned LVL_W = DEPTH_LOG2 + 1;

  logic [BYTE_W-1:0]     mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q;
  logic [DEPTH_LOG2-1:0] rptr_q;
  logic [LVL_W-1:0]      level_q;
  logic [LVL_W-1:0]      level_d;
  logic [BYTE_W-1:0]     rd_data_q;
  logic                  full_q;
  logic                  empty_q;
  logic                  afull_q;
  logic                  do_push;
  logic                  do_pop;

  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & ~empty_q;

  // Next fill count: a same-cycle push and pop cancel out.
  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (do_pop && !do_push) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  // Pointers, level and flags; flags follow level_d so they line up with level.
  always_ff @(posedge clk) begin
    if (!resetq) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      afull_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + DEPTH_LOG2'(1);
      if (do_pop)  rptr_q <= rptr_q + DEPTH_LOG2'(1);
      level_q   <= level_d;
      full_q    <= (level_d == LVL_W'(DEPTH));
      empty_q   <= (level_d == '0);
      afull_q   <= (level_d >= LVL_W'(AFULL_LEVEL));
      // Read word trails the pointer by one cycle; the consumer never loads
      // sooner than two cycles after the slot is written or rptr moves.
      rd_data_q <= mem_q[rptr_q];
    end
  end

  // Storage array, no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= push_data_i;
  end

  assign rd_data_o = rd_data_q;
  assign level_o   = level_q;
  assign full_o    = full_q;
  assign empty_o   = empty_q;
  assign afull_o   = afull_q;

endmodule

// File: rtl/ledcomm_txq.sv
// Byte queue between the UART receiver (valid / rd-pulse handshake) and the
// Ledcomm transmitter (busy / wr-pulse handshake). Bytes are only forwarded
// while the link is up; a byte whose strobe is blocked by link loss stays
// queued and is retried.
// Optional feature macro: LEDCOMM_TXQ_DROP_EN -- when defined, a byte
// offered while the queue is full is popped and discarded and the sticky
// overflow flag is set; otherwise the receiver is back-pressured and
// overflow is tied to 0.
//   clk, resetq : 12 MHz clock, synchronous active-low reset
//   in_valid    : receiver holds a byte
//   in_data     : received byte
//   in_rd       : one-cycle pop pulse to the receiver
//   link        : Ledcomm link-up status
//   lc_busy     : Ledcomm transmitter busy
//   lc_wr       : one-cycle write strobe to Ledcomm
//   lc_data     : {8'h00, byte} presented to Ledcomm
//   level       : current fill count
//   afull       : level >= AFULL_LEVEL
//   overflow    : sticky drop flag
module ledcomm_txq
  import ledcomm_txq_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 4,
  parameter int unsigned AFULL_LEVEL = 12
) (
  input  logic                  clk,
  input  logic                  resetq,
  input  logic                  in_valid,
  input  logic [BYTE_W-1:0]     in_data,
  output logic                  in_rd,
  input  logic                  link,
  input  logic                  lc_busy,
  output logic                  lc_wr,
  output logic [LC_WORD_W-1:0]  lc_data,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  afull,
  output logic                  overflow
);

  ing_state_e             ing_q;
  egr_state_e             egr_q;
  logic                   in_rd_q;
  logic                   lc_wr_q;
  logic [LC_WORD_W-1:0]   lc_data_q;
  logic                   take_c;
  logic                   push_c;
  logic                   pop_c;
  logic [BYTE_W-1:0]      rd_data;
  logic                   full;
  logic                   empty;

  // Ingress accepts a byte from the receiver in IDLE; in drop mode it also
  // accepts when full and the FIFO discards it.
`ifdef LEDCOMM_TXQ_DROP_EN
  assign take_c = (ing_q == ING_IDLE) & in_valid;
`else
  assign take_c = (ing_q == ING_IDLE) & in_valid & ~full;
`endif
  assign push_c = take_c & ~full;

  // The read pointer only advances when the strobe actually goes out.
  assign pop_c  = (egr_q == EGR_STROBE) & link;

  ledcomm_txq_fifo #(
    .DEPTH_LOG2  (DEPTH_LOG2),
    .AFULL_LEVEL (AFULL_LEVEL)
  ) u_fifo (
    .clk         (clk),
    .resetq      (resetq),
    .push_i      (push_c),
    .push_data_i (in_data),
    .pop_i       (pop_c),
    .rd_data_o   (rd_data),
    .level_o     (level),
    .full_o      (full),
    .empty_o     (empty),
    .afull_o     (afull)
  );

  // Ingress FSM: pop pulse then one gap cycle so the receiver can drop valid.
  always_ff @(posedge clk) begin
    if (!resetq) begin
      ing_q   <= ING_IDLE;
      in_rd_q <= 1'b0;
    end else begin
      in_rd_q <= 1'b0;
      case (ing_q)
        ING_IDLE: begin
          if (take_c) begin
            in_rd_q <= 1'b1;
            ing_q   <= ING_GAP;
          end
        end
        ING_GAP:  ing_q <= ING_IDLE;
        default:  ing_q <= ING_IDLE;
      endcase
    end
  end

  // Egress FSM: load the word, strobe it if the link is still up, then allow
  // one cycle for lc_busy to rise before looking again.
  always_ff @(posedge clk) begin
    if (!resetq) begin
      egr_q     <= EGR_IDLE;
      lc_wr_q   <= 1'b0;
      lc_data_q <= '0;
    end else begin
      lc_wr_q <= 1'b0;
      case (egr_q)
        EGR_IDLE: begin
          if (!empty && !lc_busy && link) egr_q <= EGR_LOAD;
        end
        EGR_LOAD: begin
          lc_data_q <= {LC_PAD, rd_data};
          egr_q     <= EGR_STROBE;
        end
        EGR_STROBE: begin
          if (link) begin
            lc_wr_q <= 1'b1;
            egr_q   <= EGR_SETTLE;
          end else begin
            egr_q   <= EGR_IDLE;
          end
        end
        EGR_SETTLE: egr_q <= EGR_IDLE;
        default:    egr_q <= EGR_IDLE;
      endcase
    end
  end

`ifdef LEDCOMM_TXQ_DROP_EN
  logic overflow_q;

  // Sticky until reset.
  always_ff @(posedge clk) begin
    if (!resetq) begin
      overflow_q <= 1'b0;
    end else if (take_c && full) begin
      overflow_q <= 1'b1;
    end
  end

  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

  assign in_rd   = in_rd_q;
  assign lc_wr   = lc_wr_q;
  assign lc_data = lc_data_q;

endmodule

// File: tb/tb_ledcomm_txq.sv
// Directed bench for ledcomm_txq: latency, fill/back-pressure, busy and link
// gating, same-cycle push/pop, ordering across pointer wrap, and reset.
module tb_ledcomm_txq;

`ifdef LEDCOMM_TXQ_DROP_EN
  localparam logic DROP = 1'b1;
`else
  localparam logic DROP = 1'b0;
`endif
  localparam int BUSY_LEN = 3;

  logic        clk = 1'b0;
  logic        resetq = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        link = 1'b0;
  logic        busy_force = 1'b0;
  logic        lc_busy;
  logic        in_rd;
  logic        lc_wr;
  logic [15:0] lc_data;
  logic [4:0]  level;
  logic        afull;
  logic        overflow;

  int total = 0;
  int bad = 0;

  ledcomm_txq #(.DEPTH_LOG2(4), .AFULL_LEVEL(12)) dut (
    .clk      (clk),
    .resetq   (resetq),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_rd    (in_rd),
    .link     (link),
    .lc_busy  (lc_busy),
    .lc_wr    (lc_wr),
    .lc_data  (lc_data),
    .level    (level),
    .afull    (afull),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Simple transmitter model: busy for a few cycles after each write.
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (lc_wr === 1'b1) busy_cnt <= BUSY_LEN;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign lc_busy = busy_force | (busy_cnt != 0);

  // Output monitor.
  logic [15:0] wr_q[$];
  bit mon_en = 1'b0;
  bit prev_wr = 1'b0;
  bit prev_rd = 1'b0;
  int dbl = 0;
  int afull_err = 0;
  int max_lvl = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (lc_wr === 1'b1) wr_q.push_back(lc_data);
      if ((lc_wr === 1'b1) && prev_wr) dbl++;
      if ((in_rd === 1'b1) && prev_rd) dbl++;
      prev_wr = (lc_wr === 1'b1);
      prev_rd = (in_rd === 1'b1);
      if (int'(level) > max_lvl) max_lvl = int'(level);
      if (afull !== (level >= 5'd12)) afull_err++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b, input int lim, output bit got);
    in_valid = 1'b1;
    in_data  = b;
    got      = 1'b0;
    for (int i = 0; i < lim && !got; i++) begin
      step();
      if (in_rd === 1'b1) got = 1'b1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int n, input int lim);
    for (int i = 0; i < lim && !(wr_q.size() >= n && level == 5'd0); i++) step();
  endtask

  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int n_ok;
    int mism;
    logic [7:0] exp_b[$];
    logic [7:0] b;
    logic [15:0] v;

    // Reset state
    repeat (3) step();
    resetq = 1'b1;
    mon_en = 1'b1;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_afull", 32'(afull), 32'd0);
    chk("rst_in_rd", 32'(in_rd), 32'd0);
    chk("rst_lc_wr", 32'(lc_wr), 32'd0);
    chk("rst_lc_data", 32'(lc_data), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);

    // 1: single byte latency, in_rd at E and lc_wr at E+3
    link = 1'b1;
    repeat (5) step();
    wr_q.delete();
    in_valid = 1'b1;
    in_data  = 8'hA5;
    step();
    chk("t1_in_rd", 32'(in_rd), 32'd1);
    chk("t1_level1", 32'(level), 32'd1);
    in_valid = 1'b0;
    step();
    chk("t1_in_rd_pulse", 32'(in_rd), 32'd0);
    chk("t1_wr_early", 32'(lc_wr), 32'd0);
    step();
    chk("t1_lc_data", 32'(lc_data), 32'h00A5);
    chk("t1_wr_early2", 32'(lc_wr), 32'd0);
    step();
    chk("t1_lc_wr", 32'(lc_wr), 32'd1);
    chk("t1_level0", 32'(level), 32'd0);
    step();
    chk("t1_lc_wr_pulse", 32'(lc_wr), 32'd0);
    chk("t1_wr_count", 32'(wr_q.size()), 32'd1);

    // 2: link down fill, afull threshold, full back-pressure, ordered drain
    link = 1'b0;
    repeat (10) step();
    wr_q.delete();
    n_ok = 0;
    for (int i = 0; i < 16; i++) begin
      push_byte(8'(i), 20, got);
      if (got) n_ok++;
      if (i == 10) begin
        chk("t2_level11", 32'(level), 32'd11);
        chk("t2_afull11", 32'(afull), 32'd0);
      end
      if (i == 11) begin
        chk("t2_level12", 32'(level), 32'd12);
        chk("t2_afull12", 32'(afull), 32'd1);
      end
    end
    chk("t2_pushes", 32'(n_ok), 32'd16);
    chk("t2_level16", 32'(level), 32'd16);
    chk("t2_afull16", 32'(afull), 32'd1);
    push_byte(8'hEE, 10, got);
    chk("t2_17th_rd", 32'(got), 32'(DROP));
    step();
    chk("t2_17th_level", 32'(level), 32'd16);
    chk("t2_overflow", 32'(overflow), 32'(DROP));
    chk("t2_no_wr_link_down", 32'(wr_q.size()), 32'd0);
    link = 1'b1;
    wait_drain(16, 1000);
    chk("t2_wr_count", 32'(wr_q.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      v = (i < wr_q.size()) ? wr_q[i] : 16'hFFFF;
      chk($sformatf("t2_byte%0d", i), 32'(v), 32'(i));
    end
    chk("t2_level_end", 32'(level), 32'd0);
    chk("t2_afull_end", 32'(afull), 32'd0);
    chk("t2_overflow_sticky", 32'(overflow), 32'(DROP));

    // 3: busy gating
    repeat (10) step();
    wr_q.delete();
    busy_force = 1'b1;
    push_byte(8'h3C, 10, got);
    repeat (200) step();
    chk("t3_no_wr_busy", 32'(wr_q.size()), 32'd0);
    chk("t3_level_held", 32'(level), 32'd1);
    busy_force = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (lc_wr === 1'b1) got = 1'b1;
    end
    chk("t3_wr_within3", 32'(got), 32'd1);
    chk("t3_lc_data", 32'(lc_data), 32'h003C);

    // 4: link drops while LOAD, so STROBE sees link low
    repeat (10) step();
    wr_q.delete();
    push_byte(8'h3C, 10, got);
    step();
    link = 1'b0;
    repeat (7) step();
    chk("t4_no_wr", 32'(wr_q.size()), 32'd0);
    chk("t4_level_kept", 32'(level), 32'd1);
    link = 1'b1;
    repeat (40) step();
    chk("t4_wr_once", 32'(wr_q.size()), 32'd1);
    v = (wr_q.size() > 0) ? wr_q[0] : 16'hFFFF;
    chk("t4_data", 32'(v), 32'h003C);
    chk("t4_level0", 32'(level), 32'd0);

    // 5a: same-cycle push and pop
    repeat (10) step();
    wr_q.delete();
    push_byte(8'h11, 10, got);
    step();
    step();
    in_valid = 1'b1;
    in_data  = 8'h22;
    step();
    chk("t5_same_rd", 32'(in_rd), 32'd1);
    chk("t5_same_wr", 32'(lc_wr), 32'd1);
    chk("t5_same_level", 32'(level), 32'd1);
    chk("t5_same_data", 32'(lc_data), 32'h0011);
    in_valid = 1'b0;
    wait_drain(2, 200);
    v = (wr_q.size() > 1) ? wr_q[1] : 16'hFFFF;
    chk("t5_second", 32'(v), 32'h0022);

    // 5b: 40 bytes with host flow control on afull, pointers wrap
    repeat (10) step();
    wr_q.delete();
    max_lvl = 0;
    n_ok = 0;
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 200 && afull === 1'b1; k++) step();
      b = 8'(i * 37 + 5);
      exp_b.push_back(b);
      push_byte(b, 200, got);
      if (got) n_ok++;
    end
    wait_drain(40, 3000);
    chk("t5_pushes", 32'(n_ok), 32'd40);
    chk("t5_wr_count", 32'(wr_q.size()), 32'd40);
    mism = 0;
    for (int i = 0; i < 40; i++) begin
      v = (i < wr_q.size()) ? wr_q[i] : 16'hFFFF;
      if (v !== {8'h00, exp_b[i]}) mism++;
    end
    chk("t5_order", 32'(mism), 32'd0);
    chk("t5_max_level", 32'(max_lvl), 32'd12);
    chk("t5_level0", 32'(level), 32'd0);

    // 6: reset while in STROBE with level 5
    repeat (20) step();
    link = 1'b0;
    for (int i = 0; i < 5; i++) push_byte(8'(8'h51 + i), 20, got);
    step();
    chk("t6_level5", 32'(level), 32'd5);
    link = 1'b1;
    step();
    step();
    chk("t6_pre_data", 32'(lc_data), 32'h0051);
    chk("t6_pre_wr", 32'(lc_wr), 32'd0);
    chk("t6_pre_overflow", 32'(overflow), 32'(DROP));
    resetq = 1'b0;
    step();
    chk("t6_level", 32'(level), 32'd0);
    chk("t6_lc_wr", 32'(lc_wr), 32'd0);
    chk("t6_in_rd", 32'(in_rd), 32'd0);
    chk("t6_lc_data", 32'(lc_data), 32'd0);
    chk("t6_afull", 32'(afull), 32'd0);
    chk("t6_overflow", 32'(overflow), 32'd0);
    step();
    resetq = 1'b1;
    wr_q.delete();
    repeat (20) step();
    chk("t6_discarded", 32'(wr_q.size()), 32'd0);
    chk("t6_level_after", 32'(level), 32'd0);

    // Global pulse and afull properties
    chk("pulse_double", 32'(dbl), 32'd0);
    chk("afull_track", 32'(afull_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ledcomm_txq.md
Name: ledcomm_txq

Overview:
- Byte queue between the UART receiver (valid/rd pulse handshake) and the Ledcomm transmitter (busy/wr pulse handshake).
- Absorbs host bursts at 1200 baud while the optical link is slow or down.
- Offers a registered almost-full flag for host flow control.
- Forwards a byte only when the link is up, and never loses a byte on link loss.

Parameters:
- DEPTH_LOG2, 4, log2 of queue depth (16 entries).
- AFULL_LEVEL, 12, fill level at or above which afull asserts; must be <= 2**DEPTH_LOG2.

Ports:
- clk  in  1  system clock, 12 MHz.
- resetq  in  1  synchronous, active-low reset, sampled on posedge clk.
- in_valid  in  1  UART receiver holds a byte.
- in_data  in  8  UART received byte.
- in_rd  out  1  one-cycle pop pulse to the UART receiver.
- link  in  1  Ledcomm link-up status.
- lc_busy  in  1  Ledcomm transmitter busy.
- lc_wr  out  1  one-cycle write strobe to Ledcomm.
- lc_data  out  16  {8'h00, byte} presented to Ledcomm.
- level  out  DEPTH_LOG2+1  current fill count, 0..2**DEPTH_LOG2.
- afull  out  1  level >= AFULL_LEVEL, registered.
- overflow  out  1  sticky drop flag; constant 0 unless the feature is compiled in.

Behaviour:
- Reset (resetq=0 at an edge): pointers, level, in_rd, lc_wr, lc_data, afull and overflow all go to 0. Both FSMs go to IDLE. Queue content is discarded, including mid-transfer. Outputs are valid from the first cycle after reset release.
- Ingress FSM, states IDLE, GAP:
  - IDLE, in_valid & !full: write in_data at wptr, wptr++, in_rd<=1, go to GAP.
  - GAP: one cycle, lets the receiver drop valid; return to IDLE.
  - IDLE, in_valid & full: no pop, stay in IDLE. Back-pressure is applied; the receiver may overrun internally.
- Egress FSM, states IDLE, LOAD, STROBE, SETTLE:
  - IDLE: if !empty & !lc_busy & link, go to LOAD.
  - LOAD: lc_data<={8'h00, mem[rptr]}, go to STROBE.
  - STROBE: if link, then lc_wr<=1, rptr++, go to SETTLE. If link has dropped, no wr, no pop, return to IDLE. The byte is retried later.
  - SETTLE: one cycle so lc_busy can rise; return to IDLE.
- lc_data is stable from LOAD until the next LOAD.
- lc_wr and in_rd are never high two consecutive cycles.
- Latency, empty queue with link=1 and lc_busy=0: in_rd at cycle n, lc_wr at cycle n+3.
- Simultaneous push and pop in the same cycle: both execute, level unchanged.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth.
- Status definitions:
  - full: level==2**DEPTH_LOG2.
  - empty: level==0.
  - level: updated each edge by +push −pop.
  - afull: registered from the next level value, so it is coincident with level.
- Link down: queue holds, fills, then back-pressures. There is no flush and no timeout.
- lc_busy high at IDLE: wait, no timeout.

Optional Feature:
- Macro: LEDCOMM_TXQ_DROP_EN.
- Defined:
  - IDLE with in_valid & full pops the byte anyway (in_rd<=1, go to GAP), discards it, and sets overflow<=1.
  - overflow clears only on reset.
  - The host never stalls the receiver; newest bytes are lost.
- Undefined: back-pressure as in Behaviour, and overflow is tied to 0.

Decomposition:
- Package ledcomm_txq_pkg holds:
  - ingress state encodings (2 values) and egress state encodings (4 values), 2-bit;
  - LC_WORD_W=16 and LC_PAD=8'h00;
  - BYTE_W=8.
- One sub-module is natural: ledcomm_txq_fifo.
  - Contents: sync RAM, pointers, level/full/empty/afull.
  - Port semantics: push and pop are single-cycle strobes; it ignores push when full and pop when empty.
- Both FSMs and the drop logic stay in ledcomm_txq.

Test Plan:
1. Single byte: link=1, lc_busy=0, in_valid with 8'hA5 at cycle 10.
   - in_rd at 11; lc_wr at 14 with lc_data=16'h00A5.
   - level 1 then 0; in_rd and lc_wr are each exactly one cycle.
2. Link down fill: link=0, push 16 bytes 8'h00..8'h0F.
   - level=16 and afull=1 (asserts at level 12).
   - A 17th in_valid gets no in_rd.
   - Raise link: 16 lc_wr pulses in order 8'h00..8'h0F, each gated by lc_busy; level returns to 0 and afull clears below 12.
3. Busy gating: queue holds 8'h3C, lc_busy=1 for 200 cycles → no lc_wr. lc_busy=0 → lc_wr within 3 cycles.
4. Link drop during LOAD, so link is low at STROBE → no lc_wr, level unchanged. Link restored → 8'h3C sent once.
5. Wrap and concurrency: 40 bytes with pushes and pops interleaved, including same-cycle push/pop → output order equals input order, level never exceeds 16.
6. Reset: assert resetq=0 with level=5 in STROBE → next cycle level=0, lc_wr=0, in_rd=0, lc_data=0. With LEDCOMM_TXQ_DROP_EN, push 17 bytes with link=0 → 17th popped, overflow=1, level=16, and overflow clears only on reset.
